// File: rtl/pc_trap_unit.sv
// pc_trap_unit: next-PC generation for the Beta processor, with trap vectors,
// a latched external interrupt and a circular trap-return stack for nested
// exceptions with hardware return (xret).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   stall            hold PC and all state except interrupt latching
//   pc_ctrl[1:0]     0 normal, 1 soft reset, 2 illop, 3 xadr
//   jump[1:0]        0/3 concat jump, 1 branch path, 2 jump register
//   b_ctrl           branch taken (used when jump=1)
//   xret             return from trap (pop stack)
//   irq              level interrupt request
//   sign_ext         sign-extended branch literal
//   id[31:0]         current instruction word
//   radata           register operand for jump register
//   ia               current PC (registered)
//   ia_plus4         ia + 4 (combinational from ia)
//   xp               top-of-stack return address, 0 when empty (registered)
//   xdepth           number of valid stack entries (registered)
//   ovf, unf         sticky overflow / underflow flags (registered)
//   irq_taken        one-cycle pulse while ia is at the interrupt vector
module pc_trap_unit #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(32'h8000_0000),
    parameter logic [WIDTH-1:0]  ILLOP_VEC = WIDTH'(32'h8000_0004),
    parameter logic [WIDTH-1:0]  XADR_VEC  = WIDTH'(32'h8000_0008),
    parameter logic [WIDTH-1:0]  IRQ_VEC   = WIDTH'(32'h8000_000C),
    parameter int unsigned       SUP_BIT   = WIDTH - 1,
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       DW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_ctrl,
    input  logic [1:0]       jump,
    input  logic             b_ctrl,
    input  logic             xret,
    input  logic             irq,
    input  logic [WIDTH-1:0] sign_ext,
    input  logic [31:0]      id,
    input  logic [WIDTH-1:0] radata,
    output logic [WIDTH-1:0] ia,
    output logic [WIDTH-1:0] ia_plus4,
    output logic [WIDTH-1:0] xp,
    output logic [DW-1:0]    xdepth,
    output logic             ovf,
    output logic             unf,
    output logic             irq_taken
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [PW-1:0]    wp_q;
    logic             irq_pend;

    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] cat_target;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] path_target;
    logic [WIDTH-1:0] ia_next;
    logic             do_push;
    logic             do_pop;
    logic             do_clear;
    logic             do_irq;
    logic             set_unf;

    // Opcode bits of id are not part of any target.
    logic unused_id;
    assign unused_id = ^id[31:26];

    // Circular pointer arithmetic modulo DEPTH (DEPTH need not be a power of 2).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (32'(p) == DEPTH - 1) return '0;
        return p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (p == '0) return PW'(DEPTH - 1);
        return p - PW'(1);
    endfunction

    assign ia_plus4 = ia + WIDTH'(4);

    // Candidate targets; jump-register can drop but never raise the supervisor bit.
    always_comb begin
        br_target  = ia_plus4 + (sign_ext << 2);
        cat_target = {ia_plus4[WIDTH-1:28], id[25:0], 2'b00};
        jr_target  = radata;
        jr_target[SUP_BIT] = ia[SUP_BIT] & radata[SUP_BIT];
        case (jump)
            2'd1:    path_target = b_ctrl ? br_target : ia_plus4;
            2'd2:    path_target = jr_target;
            default: path_target = cat_target;
        endcase
    end

    // One action per cycle, chosen by priority.
    always_comb begin
        ia_next  = ia;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_clear = 1'b0;
        do_irq   = 1'b0;
        set_unf  = 1'b0;
        if (!stall) begin
            if (pc_ctrl == 2'd1) begin
                ia_next  = RESET_VEC;
                do_clear = 1'b1;
            end else if (pc_ctrl == 2'd2) begin
                ia_next = ILLOP_VEC;
                do_push = 1'b1;
            end else if (pc_ctrl == 2'd3) begin
                ia_next = XADR_VEC;
                do_push = 1'b1;
            end else if (irq_pend && !ia[SUP_BIT]) begin
                ia_next = IRQ_VEC;
                do_push = 1'b1;
                do_irq  = 1'b1;
            end else if (xret) begin
                if (xdepth != '0) begin
                    ia_next = xp;
                    do_pop  = 1'b1;
                end else begin
                    ia_next = jr_target;
                    set_unf = 1'b1;
                end
            end else begin
                ia_next = path_target;
            end
        end
    end

    // Stack storage carries no reset; validity is tracked by xdepth.
    always_ff @(posedge clk) begin
        if (!reset && do_push) stack_q[wp_q] <= ia_plus4;
    end

    // PC, pointers, flags and interrupt latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            ia        <= RESET_VEC;
            wp_q      <= '0;
            xdepth    <= '0;
            xp        <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            irq_pend  <= 1'b0;
            irq_taken <= 1'b0;
        end else begin
            ia        <= ia_next;
            irq_taken <= do_irq;
            if (do_clear || do_irq) irq_pend <= 1'b0;
            else                    irq_pend <= irq_pend | irq;

            if (do_clear) begin
                wp_q   <= '0;
                xdepth <= '0;
                xp     <= '0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else if (do_push) begin
                wp_q <= ptr_inc(wp_q);
                xp   <= ia_plus4;
                // Full: the write at wp lands on the oldest entry.
                if (xdepth == DW'(DEPTH)) ovf    <= 1'b1;
                else                      xdepth <= xdepth + DW'(1);
            end else if (do_pop) begin
                wp_q   <= ptr_dec(wp_q);
                xdepth <= xdepth - DW'(1);
                // New top sits two slots behind the current write pointer.
                xp     <= (xdepth > DW'(1)) ? stack_q[ptr_dec(ptr_dec(wp_q))] : '0;
            end

            if (set_unf) unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_trap_unit.sv
// Bench for pc_trap_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_pc_trap_unit;

    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] ILL_V = 32'h8000_0004;
    localparam logic [31:0] IRQ_V = 32'h8000_000C;
    localparam int          DEP   = 4;

    logic        clk = 1'b0;
    logic        reset, stall, b_ctrl, xret, irq;
    logic [1:0]  pc_ctrl, jump;
    logic [31:0] sign_ext, id, radata;
    logic [31:0] ia, ia_plus4, xp;
    logic [2:0]  xdepth;
    logic        ovf, unf, irq_taken;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    logic [31:0] m_ia;
    logic [31:0] m_stk[$];
    bit          m_ovf, m_unf, m_pend, m_taken;

    pc_trap_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_ctrl(pc_ctrl), .jump(jump),
        .b_ctrl(b_ctrl), .xret(xret), .irq(irq), .sign_ext(sign_ext), .id(id),
        .radata(radata), .ia(ia), .ia_plus4(ia_plus4), .xp(xp), .xdepth(xdepth),
        .ovf(ovf), .unf(unf), .irq_taken(irq_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_xp();
        if (m_stk.size() == 0) return 32'h0;
        return m_stk[$];
    endfunction

    function automatic void m_push(input logic [31:0] v);
        if (m_stk.size() == DEP) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
        end
        m_stk.push_back(v);
    endfunction

    // Next-state of the architectural model from the current inputs.
    task automatic model_step();
        logic [31:0] ia4, jr, path;
        ia4 = m_ia + 32'd4;
        jr  = (radata & 32'h7FFF_FFFF) | (radata & m_ia & 32'h8000_0000);
        case (jump)
            2'd1:    path = b_ctrl ? ia4 + sign_ext * 32'd4 : ia4;
            2'd2:    path = jr;
            default: path = {ia4[31:28], id[25:0], 2'b00};
        endcase
        if (reset) begin
            m_ia = RST_V; m_stk.delete(); m_ovf = 0; m_unf = 0; m_pend = 0; m_taken = 0;
        end else if (stall) begin
            m_pend  = m_pend | irq;
            m_taken = 1'b0;
        end else begin
            m_taken = 1'b0;
            if (pc_ctrl == 2'd1) begin
                m_ia = RST_V; m_stk.delete(); m_ovf = 0; m_unf = 0; m_pend = 0;
            end else if (pc_ctrl == 2'd2 || pc_ctrl == 2'd3) begin
                m_push(ia4);
                m_ia   = (pc_ctrl == 2'd2) ? ILL_V : 32'h8000_0008;
                m_pend = m_pend | irq;
            end else if (m_pend && !m_ia[31]) begin
                m_push(ia4);
                m_ia = IRQ_V; m_pend = 0; m_taken = 1'b1;
            end else if (xret) begin
                if (m_stk.size() > 0) m_ia = m_stk.pop_back();
                else begin m_ia = jr; m_unf = 1'b1; end
                m_pend = m_pend | irq;
            end else begin
                m_ia   = path;
                m_pend = m_pend | irq;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ia", ia, m_ia);
            check("ia_plus4", ia_plus4, m_ia + 32'd4);
            check("xp", xp, m_xp());
            check("xdepth", 32'(xdepth), 32'(m_stk.size()));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("unf", 32'(unf), 32'(m_unf));
            check("irq_taken", 32'(irq_taken), 32'(m_taken));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; pc_ctrl = 2'd0; jump = 2'd1; b_ctrl = 0;
        xret = 0; irq = 0; sign_ext = '0; id = '0; radata = '0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check({"lit_", name}, act, exp);
    endtask

    initial begin
        idle();
        reset = 1;
        m_ia = '0; m_ovf = 0; m_unf = 0; m_pend = 0; m_taken = 0;
        cyc(); cyc();
        chk_en = 1'b1;
        lit("rst_ia", ia, 32'h8000_0000);
        lit("rst_xdepth", 32'(xdepth), 32'd0);
        lit("rst_xp", xp, 32'd0);

        // Sequential fetch
        reset = 0;
        cyc(); lit("seq1", ia, 32'h8000_0004);
        cyc(); lit("seq2", ia, 32'h8000_0008);

        // Jump-register from supervisor into user space
        jump = 2'd2; radata = 32'h0000_0100;
        cyc(); lit("jr_100", ia, 32'h0000_0100);
        jump = 2'd1; b_ctrl = 1; sign_ext = 32'hFFFF_FFFF;
        cyc(); lit("br_back", ia, 32'h0000_0100);
        jump = 2'd2; radata = 32'h8000_0040;
        cyc(); lit("jr_supblock", ia, 32'h0000_0040);
        jump = 2'd0; id = 32'hFC00_0123;
        cyc(); lit("concat", ia, 32'h0000_048C);
        jump = 2'd1; b_ctrl = 1; sign_ext = 32'h0000_0010;
        cyc(); lit("br_fwd", ia, 32'h0000_04D0);
        jump = 2'd3; id = 32'h0000_0200;
        cyc(); lit("concat3", ia, 32'h0000_0800);

        // Interrupt latched during stall
        jump = 2'd2; radata = 32'h0000_0200;
        cyc(); lit("jr_200", ia, 32'h0000_0200);
        jump = 2'd1; b_ctrl = 0; stall = 1; irq = 1;
        cyc(); lit("stall_hold1", ia, 32'h0000_0200);
        irq = 0;
        cyc(); lit("stall_hold2", ia, 32'h0000_0200);
        stall = 0;
        cyc();
        lit("irq_ia", ia, IRQ_V);
        lit("irq_xp", xp, 32'h0000_0204);
        lit("irq_taken", 32'(irq_taken), 32'd1);
        lit("irq_depth", 32'(xdepth), 32'd1);
        xret = 1;
        cyc();
        lit("xret_ia", ia, 32'h0000_0204);
        lit("xret_depth", 32'(xdepth), 32'd0);
        lit("taken_drop", 32'(irq_taken), 32'd0);
        xret = 0;

        // Five nested illops with distinct return addresses
        for (int k = 0; k < 5; k++) begin
            pc_ctrl = 2'd2;
            cyc();
            pc_ctrl = 2'd0;
            if (k < 4) begin
                jump = 2'd1; b_ctrl = 1; sign_ext = 32'(k + 1);
                cyc();
            end
        end
        lit("ovf_set", 32'(ovf), 32'd1);
        lit("ovf_depth", 32'(xdepth), 32'd4);
        lit("ovf_xp", xp, 32'h8000_001C);
        b_ctrl = 0; xret = 1;
        cyc(); lit("pop1", ia, 32'h8000_001C);
        cyc(); lit("pop2", ia, 32'h8000_0018);
        cyc(); lit("pop3", ia, 32'h8000_0014);
        cyc(); lit("pop4", ia, 32'h8000_0010);
        lit("pop4_xp", xp, 32'd0);
        radata = 32'h0000_0300;
        cyc();
        lit("unf_ia", ia, 32'h0000_0300);
        lit("unf_set", 32'(unf), 32'd1);
        xret = 0;

        // Interrupt held off in supervisor mode
        pc_ctrl = 2'd1;
        cyc(); lit("soft_rst_unf", 32'(unf), 32'd0);
        pc_ctrl = 2'd0; jump = 2'd1; b_ctrl = 1; sign_ext = 32'd3;
        cyc(); lit("sup_10", ia, 32'h8000_0010);
        b_ctrl = 0; irq = 1;
        cyc(); cyc();
        lit("sup_hold", ia, 32'h8000_0018);
        lit("sup_notaken", 32'(irq_taken), 32'd0);
        jump = 2'd2; radata = 32'h0000_0400;
        cyc(); lit("to_user", ia, 32'h0000_0400);
        irq = 0; jump = 2'd1;
        cyc();
        lit("irq2_ia", ia, IRQ_V);
        lit("irq2_xp", xp, 32'h0000_0404);

        // Fill to overflow, unwind to depth 2, then soft reset
        pc_ctrl = 2'd2;
        repeat (4) cyc();
        pc_ctrl = 2'd0; xret = 1;
        repeat (2) cyc();
        xret = 0;
        lit("mid_depth", 32'(xdepth), 32'd2);
        lit("mid_ovf", 32'(ovf), 32'd1);
        // Stall suppresses a pending illop
        stall = 1; pc_ctrl = 2'd2;
        cyc();
        lit("stall_nopush", 32'(xdepth), 32'd2);
        stall = 0; pc_ctrl = 2'd1;
        cyc();
        lit("sr_ia", ia, RST_V);
        lit("sr_depth", 32'(xdepth), 32'd0);
        lit("sr_ovf", 32'(ovf), 32'd0);
        lit("sr_xp", xp, 32'd0);

        // Same scenario ended by the reset pin
        pc_ctrl = 2'd2;
        repeat (5) cyc();
        pc_ctrl = 2'd0; xret = 1;
        repeat (2) cyc();
        xret = 0;
        reset = 1;
        cyc();
        lit("hr_ia", ia, RST_V);
        lit("hr_depth", 32'(xdepth), 32'd0);
        lit("hr_ovf", 32'(ovf), 32'd0);
        lit("hr_unf", 32'(unf), 32'd0);
        lit("hr_xp", xp, 32'd0);
        reset = 0;
        cyc(); lit("post_rst", ia, 32'h8000_0004);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
